// File: rtl/serial_pkg.sv
// Shared serial-protocol types and constants for the bit-serial datapath
// (word transmitter, serial incrementer and friends).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  // Level driven on the serial data line whenever no word bit is present.
  localparam logic SERIAL_IDLE_BIT = 1'b0;

  // Bits needed for a counter that must hold 0..max_val; never less than 1.
  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// One-entry holding register: a word parked while the shifter is busy,
// with a valid flag that drives the upstream ready.
module serial_hold_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    valid_d = valid_q;
    if (push_i) begin
      valid_d = 1'b1;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the data word carries no reset; it is only observed while valid_q
  // is set, so resetting it would add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (push_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: LSB-first bit stream with sof/eof
// framing, a one-word pending buffer and an optional idle gap between words.
module serial_word_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             b,
  output logic             bit_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  import serial_pkg::*;

  localparam int unsigned CW = ctr_width(WIDTH);
  localparam int unsigned GW = ctr_width(GAP);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             b_q, b_d;
  logic             bit_valid_q, bit_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic             hold_push, hold_pop, hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             accept, load;
  logic [WIDTH-1:0] load_word;
  logic             shifting_d;

  serial_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (hold_push),
    .data_i  (data_in),
    .pop_i   (hold_pop),
    .valid_o (hold_valid),
    .data_o  (hold_data)
  );

  assign ready_out = !hold_valid;
  assign accept    = valid_in && ready_out;

  // The parameter GAP shadows the enum literal, so the state is package-scoped.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    hold_push = 1'b0;
    hold_pop  = 1'b0;
    load      = 1'b0;
    load_word = data_in;

    unique case (state_q)
      IDLE: begin
        load = accept;
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == BIT_LAST) begin
          if (GAP > 0) begin
            state_d   = serial_pkg::GAP;
            gap_d     = '0;
            hold_push = accept;
          end else if (hold_valid) begin
            load      = 1'b1;
            load_word = hold_data;
            hold_pop  = 1'b1;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_push = accept;
        end
      end
      serial_pkg::GAP: begin
        if (gap_q == GAP_LAST) begin
          if (hold_valid) begin
            load      = 1'b1;
            load_word = hold_data;
            hold_pop  = 1'b1;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d     = gap_q + GW'(1);
          hold_push = accept;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = SHIFT;
      shift_d = load_word;
      cnt_d   = '0;
    end

    // Outputs are computed from the next state so they leave a flop.
    shifting_d  = (state_d == SHIFT);
    b_d         = shifting_d ? shift_d[0] : SERIAL_IDLE_BIT;
    bit_valid_d = shifting_d;
    sof_d       = shifting_d && (cnt_d == '0);
    eof_d       = shifting_d && (cnt_d == BIT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      b_q         <= SERIAL_IDLE_BIT;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      b_q         <= b_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign b         = b_q;
  assign bit_valid = bit_valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign busy      = (state_q != IDLE) || hold_valid;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: three instances (4/0, 4/2, 1/0)
// checked every cycle against a word-schedule reference model.
module tb_serial_word_tx;

  typedef struct {
    logic [3:0] word;
    int         acc;
    int         start;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din [3];
  logic [2:0] vin;
  logic [2:0] rdy, bo, bvo, sofo, eofo, busyo;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit         rand_gate = 1'b0;

  rec_t       recs  [3][$];
  logic [3:0] srcq  [3][$];
  int         free_t [3];
  bit         pres   [3];

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(4), .GAP(0)) u_l0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .valid_in(vin[0]),
    .ready_out(rdy[0]), .b(bo[0]), .bit_valid(bvo[0]), .sof(sofo[0]),
    .eof(eofo[0]), .busy(busyo[0])
  );

  serial_word_tx #(.WIDTH(4), .GAP(2)) u_l1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .valid_in(vin[1]),
    .ready_out(rdy[1]), .b(bo[1]), .bit_valid(bvo[1]), .sof(sofo[1]),
    .eof(eofo[1]), .busy(busyo[1])
  );

  serial_word_tx #(.WIDTH(1), .GAP(0)) u_l2 (
    .clk(clk), .reset(reset), .data_in(din[2][0:0]), .valid_in(vin[2]),
    .ready_out(rdy[2]), .b(bo[2]), .bit_valid(bvo[2]), .sof(sofo[2]),
    .eof(eofo[2]), .busy(busyo[2])
  );

  function automatic int lw(int l);
    return (l == 2) ? 1 : 4;
  endfunction

  function automatic int lg(int l);
    return (l == 1) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // A word is pending from the edge it was accepted until the edge it starts.
  function automatic bit model_pending(int l, int c);
    for (int i = 0; i < recs[l].size(); i++)
      if (recs[l][i].acc <= c && c < recs[l][i].start) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_lane(input int l, input int c);
    logic eb, ebv, es, ee, ebusy;
    int   s, k;
    eb = 0; ebv = 0; es = 0; ee = 0; ebusy = 0;
    for (int i = 0; i < recs[l].size(); i++) begin
      s = recs[l][i].start;
      if (c >= s && c < s + lw(l)) begin
        k   = c - s;
        eb  = recs[l][i].word[k];
        ebv = 1'b1;
        es  = (k == 0);
        ee  = (k == lw(l) - 1);
      end
      if (c >= s && c < s + lw(l) + lg(l)) ebusy = 1'b1;
    end
    if (model_pending(l, c)) ebusy = 1'b1;
    check($sformatf("L%0d.b@%0d", l, c), 32'(bo[l]), 32'(eb));
    check($sformatf("L%0d.bit_valid@%0d", l, c), 32'(bvo[l]), 32'(ebv));
    check($sformatf("L%0d.sof@%0d", l, c), 32'(sofo[l]), 32'(es));
    check($sformatf("L%0d.eof@%0d", l, c), 32'(eofo[l]), 32'(ee));
    check($sformatf("L%0d.busy@%0d", l, c), 32'(busyo[l]), 32'(ebusy));
    check($sformatf("L%0d.ready@%0d", l, c), 32'(rdy[l]), 32'(!model_pending(l, c)));
  endtask

  // Drive inputs at the falling edge, advance one rising edge, check at the next falling edge.
  task automatic step();
    for (int l = 0; l < 3; l++) begin
      bit   go;
      int   e;
      rec_t r;
      go = (srcq[l].size() > 0) && (pres[l] || !rand_gate || ($urandom_range(0, 2) != 0));
      pres[l] = go;
      vin[l]  = go;
      din[l]  = go ? srcq[l][0] : 4'h0;
      if (go && !model_pending(l, cyc)) begin
        e       = cyc + 1;
        r.word  = srcq[l][0];
        r.acc   = e;
        r.start = (e > free_t[l]) ? e : free_t[l];
        free_t[l] = r.start + lw(l) + lg(l);
        recs[l].push_back(r);
        void'(srcq[l].pop_front());
        pres[l] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check_lane(l, cyc);
      while (recs[l].size() > 0 && recs[l][0].start + lw(l) + lg(l) < cyc - 2)
        void'(recs[l].pop_front());
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_state(input string tag);
    for (int l = 0; l < 3; l++) begin
      check($sformatf("%s.L%0d.b", tag, l), 32'(bo[l]), 32'd0);
      check($sformatf("%s.L%0d.bit_valid", tag, l), 32'(bvo[l]), 32'd0);
      check($sformatf("%s.L%0d.sof", tag, l), 32'(sofo[l]), 32'd0);
      check($sformatf("%s.L%0d.eof", tag, l), 32'(eofo[l]), 32'd0);
      check($sformatf("%s.L%0d.busy", tag, l), 32'(busyo[l]), 32'd0);
      check($sformatf("%s.L%0d.ready", tag, l), 32'(rdy[l]), 32'd1);
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < 3; l++) begin
      recs[l].delete();
      srcq[l].delete();
      free_t[l] = 0;
      pres[l]   = 1'b0;
      vin[l]    = 1'b0;
      din[l]    = 4'h0;
    end
  endtask

  initial begin
    clear_model();
    reset = 1'b0;
    #2;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b1;

    // Single word, back-to-back with gap, and one-bit words.
    srcq[0].push_back(4'h1);
    srcq[1].push_back(4'h3); srcq[1].push_back(4'hC); srcq[1].push_back(4'hF);
    srcq[2].push_back(4'h1); srcq[2].push_back(4'h0); srcq[2].push_back(4'h1);
    run(20);

    // Back-to-back words then a third held off by the full pending buffer.
    srcq[0].push_back(4'hA); srcq[0].push_back(4'h5); srcq[0].push_back(4'h9);
    run(16);

    // Reset in bit 2 of 4'hE while 4'h7 sits in the pending buffer.
    srcq[0].push_back(4'hE); srcq[0].push_back(4'h7);
    run(3);
    check("mid.L0.bit2_valid", 32'(bvo[0]), 32'd1);
    check("mid.L0.pending", 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    clear_model();
    #1;
    check_reset_state("mid");
    #1;
    reset = 1'b1;
    srcq[0].push_back(4'h1);
    run(8);

    // Randomized traffic with irregular valid, values and backpressure.
    rand_gate = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < 3; l++)
        if (srcq[l].size() < 3 && $urandom_range(0, 1) == 1)
          srcq[l].push_back((lw(l) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15)));
      step();
    end
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
